spi_controller: RTL and testbench

- SPI mode-0 controller (initiator) that drives 16-bit register-access frames into the design's SPI register-file peripherals.
- Accepts one request at a time over a valid/ready handshake and serialises it MSB first on sclk/cs_n/mosi.
- For reads, captures the 8-bit data phase from miso and returns it on a one-cycle response strobe.
- Frame format: bit15 = write flag (1 = write, 0 = read), bits14:8 = 7-bit address, bits7:0 = write data (driven 0 for reads).

---
 rtl/spi_controller.sv | 124 ++++++++++++
 tb/tb_spi_controller.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_controller.sv
// SPI mode-0 initiator for 16-bit register-access frames.
// Frame: {write, addr[6:0], data[7:0]}, MSB first; read data is the last 8 miso bits.
module spi_controller #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       sclk,
  output logic       cs_n,
  output logic       mosi,
  input  logic       miso
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
  localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);
  localparam logic [15:0] IDLE_LAST  = 16'(CS_IDLE - 1);

  logic [2:0]  state;
  logic [15:0] cnt;
  logic [3:0]  bit_cnt;
  logic [15:0] tx_sr;
  logic [7:0]  rx_sr;

  assign req_ready = (state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      sclk      <= 1'b0;
      cs_n      <= 1'b1;
      mosi      <= 1'b0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            tx_sr <= {req_write, req_addr,
                      req_write ? req_data : 8'h00};
            mosi  <= req_write;
            cs_n  <= 1'b0;
            busy  <= 1'b1;
            cnt   <= '0;
            state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt     <= '0;
            bit_cnt <= '0;
            state   <= S_SHIFT;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_SHIFT: begin
          if (cnt != DIV_LAST) begin
            cnt <= cnt + 16'd1;
          end else begin
            cnt  <= '0;
            sclk <= ~sclk;
            // rising edge samples, falling edge advances
            if (!sclk) begin
              rx_sr <= {rx_sr[6:0], miso};
            end else if (bit_cnt == 4'd15) begin
              state <= S_HOLD;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              tx_sr   <= {tx_sr[14:0], 1'b0};
              mosi    <= tx_sr[14];
            end
          end
        end
        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt       <= '0;
            cs_n      <= 1'b1;
            mosi      <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_data  <= rx_sr;
            state     <= S_GAP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_GAP: begin
          if (cnt == IDLE_LAST) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: default and fastest configurations,
// random frames scored against a frame-level model.
module tb_spi_controller;

  localparam int D_DIV = 4, D_SU = 2, D_HO = 2, D_ID = 2;
  localparam int F_DIV = 1, F_SU = 1, F_HO = 1, F_ID = 1;

  typedef struct {
    logic [15:0] frame;
    logic [7:0]  rx;
    int          cs_len;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic sel;
  logic req_valid, req_write;
  logic [6:0] req_addr;
  logic [7:0] req_data;
  logic miso;

  logic r0_ready, r0_rv, r0_busy, r0_sclk, r0_cs, r0_mosi;
  logic r1_ready, r1_rv, r1_busy, r1_sclk, r1_cs, r1_mosi;
  logic [7:0] r0_rd, r1_rd;

  logic ready_m, rv_m, busy_m, sclk_m, cs_m, mosi_m;
  logic [7:0] rd_m;

  int ntests = 0;
  int nfail = 0;
  exp_t q[$];
  logic [15:0] cur_miso = '0;

  always #5 clk = ~clk;

  spi_controller #(
    .CLK_DIV(D_DIV), .CS_SETUP(D_SU),
    .CS_HOLD(D_HO), .CS_IDLE(D_ID)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid & ~sel), .req_ready(r0_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_data(req_data), .rsp_valid(r0_rv),
    .rsp_data(r0_rd), .busy(r0_busy), .sclk(r0_sclk),
    .cs_n(r0_cs), .mosi(r0_mosi), .miso(miso)
  );

  spi_controller #(
    .CLK_DIV(F_DIV), .CS_SETUP(F_SU),
    .CS_HOLD(F_HO), .CS_IDLE(F_ID)
  ) u_fast (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid & sel), .req_ready(r1_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_data(req_data), .rsp_valid(r1_rv),
    .rsp_data(r1_rd), .busy(r1_busy), .sclk(r1_sclk),
    .cs_n(r1_cs), .mosi(r1_mosi), .miso(miso)
  );

  assign ready_m = sel ? r1_ready : r0_ready;
  assign rv_m    = sel ? r1_rv    : r0_rv;
  assign rd_m    = sel ? r1_rd    : r0_rd;
  assign busy_m  = sel ? r1_busy  : r0_busy;
  assign sclk_m  = sel ? r1_sclk  : r0_sclk;
  assign cs_m    = sel ? r1_cs    : r0_cs;
  assign mosi_m  = sel ? r1_mosi  : r0_mosi;

  task automatic chk(input string nm, input int act,
                     input int exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h want 0x%0h",
               nm, act, exp);
    end
  endtask

  function automatic int cs_len_of(input logic s);
    if (s) return F_SU + 32 * F_DIV + F_HO;
    return D_SU + 32 * D_DIV + D_HO;
  endfunction

  function automatic int idle_of(input logic s);
    return s ? F_ID : D_ID;
  endfunction

  // Monitor: peripheral model plus frame reassembly
  int m_rises = 0, m_cslen = 0, gap_cd = 0;
  int high_run = 0, m_rsp_cnt = 0;
  logic [15:0] m_frame = '0, mon_sh = '0;
  logic m_viol = 0, m_edge_bad = 0, have_prev = 0;
  logic prev_sclk = 0, prev_cs = 1, prev_rsp = 0;
  exp_t mon_e;

  assign miso = mon_sh[15];

  always @(negedge clk) begin
    if (!rst_n) begin
      m_rises = 0; m_cslen = 0; m_frame = '0;
      m_viol = 0; gap_cd = 0; high_run = 0;
      have_prev = 0; prev_sclk = 0; prev_cs = 1;
      prev_rsp = 0; mon_sh = cur_miso;
    end else begin
      if (prev_rsp) chk("rsp_pulse", int'(rv_m), 0);
      if (gap_cd > 0) begin
        gap_cd--;
        if (gap_cd == 0)
          chk("idle_after_gap",
              int'({busy_m, ready_m}), 1);
      end
      if (!cs_m) begin
        if (prev_cs && have_prev) begin
          ntests++;
          if (high_run < idle_of(sel)) begin
            nfail++;
            $display("FAIL cs_gap: got %0d want >=%0d",
                     high_run, idle_of(sel));
          end
        end
        high_run = 0;
        m_cslen++;
        if (ready_m || !busy_m) m_viol = 1;
        if (sclk_m && !prev_sclk) begin
          m_frame = {m_frame[14:0], mosi_m};
          m_rises++;
          mon_sh = {mon_sh[14:0], 1'b0};
        end
      end else begin
        if (sclk_m) m_edge_bad = 1;
        high_run++;
      end
      if (rv_m) begin
        m_rsp_cnt++;
        if (q.size() == 0) begin
          chk("unexpected_rsp", int'(rv_m), 0);
        end else begin
          mon_e = q.pop_front();
          chk("mosi_frame", int'(m_frame),
              int'(mon_e.frame));
          chk("sclk_rises", m_rises, 16);
          chk("cs_low_len", m_cslen, mon_e.cs_len);
          chk("rsp_data", int'(rd_m), int'(mon_e.rx));
          chk("ready_busy_in_frame", int'(m_viol), 0);
          chk("busy_at_rsp", int'(busy_m), 1);
        end
        gap_cd = idle_of(sel);
        have_prev = 1;
      end
      if (cs_m) begin
        m_rises = 0; m_cslen = 0;
        m_frame = '0; m_viol = 0;
        mon_sh = cur_miso;
      end
      prev_sclk = sclk_m;
      prev_cs = cs_m;
      prev_rsp = rv_m;
    end
  end

  task automatic send(input logic w, input logic [6:0] a,
                      input logic [7:0] d,
                      input logic [15:0] mw,
                      input logic keep);
    exp_t e;
    int t;
    cur_miso = mw;
    @(negedge clk);
    req_write = w; req_addr = a;
    req_data = d; req_valid = 1'b1;
    t = 0;
    while (!ready_m && t < 4000) begin
      @(negedge clk);
      t++;
    end
    if (!ready_m) begin
      chk("accept_timeout", int'(ready_m), 1);
      req_valid = 1'b0;
      return;
    end
    e.frame = {w, a, w ? d : 8'h00};
    e.rx = mw[7:0];
    e.cs_len = cs_len_of(sel);
    q.push_back(e);
    @(posedge clk);
    #1;
    if (!keep) req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr = 7'($urandom);
    req_data = 8'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() > 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_queue", q.size(), 0);
    repeat (10) @(negedge clk);
  endtask

  task automatic rand_frames(input int n);
    for (int i = 0; i < n; i++)
      send(1'($urandom), 7'($urandom), 8'($urandom),
           16'($urandom), 1'($urandom));
    req_valid = 1'b0;
  endtask

  initial begin
    int t, rsp_before;
    sel = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_data = '0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctl", int'({r0_sclk, r0_cs, r0_mosi,
        r0_rv, r0_busy, r0_ready}), 'b010001);
    chk("reset_rsp_data", int'(r0_rd), 0);
    chk("reset_ctl_fast", int'({r1_sclk, r1_cs,
        r1_mosi, r1_rv, r1_busy, r1_ready}), 'b010001);
    rst_n = 1'b1;

    send(1'b1, 7'h03, 8'h5A, 16'($urandom), 1'b0);
    send(1'b0, 7'h04, 8'h77,
         {8'($urandom), 8'hA5}, 1'b0);
    send(1'b1, 7'h11, 8'hC3, 16'($urandom), 1'b1);
    send(1'b0, 7'h6E, 8'h3C, 16'($urandom), 1'b0);
    rand_frames(5);
    drain();

    send(1'b1, 7'h2A, 8'h3C, 16'($urandom), 1'b0);
    t = 0;
    while (m_rises < 7 && t < 2000) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("reach_7th_rise", m_rises, 7);
    rsp_before = m_rsp_cnt;
    rst_n = 1'b0;
    #1;
    chk("rst_midframe_outs",
        int'({cs_m, sclk_m, mosi_m, rv_m}), 'b1000);
    q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", int'(ready_m), 1);
    repeat (200) @(negedge clk);
    chk("no_rsp_after_rst", m_rsp_cnt, rsp_before);
    send(1'b1, 7'h01, 8'hFF, 16'($urandom), 1'b0);
    drain();

    sel = 1'b1;
    repeat (5) @(negedge clk);
    send(1'b1, 7'h00, 8'h81, 16'($urandom), 1'b0);
    rand_frames(12);
    drain();

    chk("no_sclk_while_cs_high", int'(m_edge_bad), 0);
    $display("[TB] %0d tests run, %0d failed",
             ntests, nfail);
    $finish;
  end

endmodule
